// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller.
// Exception codes, exception flag bit positions, CP0 register numbers,
// the controller state type and the exception priority encoder.
package except_ctrl_pkg;

  // Exception codes handed to CP0 on o_excepttype
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID = 32'h0000_000A;
  localparam logic [31:0] EXC_OV      = 32'h0000_000C;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

  // Bit positions inside the per-instruction exception flag word
  localparam int EXC_BIT_SYSCALL = 8;
  localparam int EXC_BIT_INVALID = 9;
  localparam int EXC_BIT_TRAP    = 10;
  localparam int EXC_BIT_OV      = 11;
  localparam int EXC_BIT_ERET    = 12;

  // CP0 register numbers used by MTC0
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Fixed-priority encoder: interrupt first, ERET last.
  // flags is the [12:8] slice of the exception flag word.
  function automatic logic [31:0] prio_code(input logic int_req, input logic [4:0] flags);
    logic [31:0] code;
    code = EXC_NONE;
    if (int_req)                             code = EXC_INT;
    else if (flags[EXC_BIT_SYSCALL - 8])     code = EXC_SYSCALL;
    else if (flags[EXC_BIT_INVALID - 8])     code = EXC_INVALID;
    else if (flags[EXC_BIT_TRAP - 8])        code = EXC_TRAP;
    else if (flags[EXC_BIT_OV - 8])          code = EXC_OV;
    else if (flags[EXC_BIT_ERET - 8])        code = EXC_ERET;
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_cp0_bypass.sv
// Purpose: forwards an MTC0 still in WB onto the effective Status/Cause/EPC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; values follow their inputs every cycle.
// Ports: cp0_status/cause/epc (registered CP0 values), wb_we/waddr/wdata
// (MTC0 in WB), status_eff/cause_eff/epc_eff (forwarded values).
module cp0_bypass
  import except_ctrl_pkg::*;
(
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] status_eff,
  output logic [31:0] cause_eff,
  output logic [31:0] epc_eff
);

  always_comb begin
    status_eff = cp0_status;
    cause_eff  = cp0_cause;
    epc_eff    = cp0_epc;
    if (wb_we && wb_waddr == CP0_REG_STATUS) status_eff = wb_wdata;
    if (wb_we && wb_waddr == CP0_REG_EPC)    epc_eff    = wb_wdata;
    // Only the software interrupt bits of Cause are writable by MTC0,
    // so only those are forwarded.
    if (wb_we && wb_waddr == CP0_REG_CAUSE)  cause_eff[9:8] = wb_wdata[9:8];
  end

endmodule

// File: rtl/except_ctrl.sv
// Purpose: MEM-stage exception detection, prioritisation and flush/redirect sequencing.
// Latency: o_excepttype same cycle; o_flush/o_new_pc registered, held FLUSH_CYCLES cycles.
// Backpressure: none; exceptions arriving while flushing are discarded.
// Ports: i_mem_* (MEM instruction), i_cp0_* (registered CP0), i_wb_cp0_* (MTC0 in WB),
// o_excepttype/o_current_inst_addr/o_is_in_delayslot (to CP0), o_flush/o_new_pc (to pipeline).
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_pc,
  input  logic        i_mem_in_delayslot,
  input  logic [31:0] i_mem_except,
  input  logic [31:0] i_cp0_status,
  input  logic [31:0] i_cp0_cause,
  input  logic [31:0] i_cp0_epc,
  input  logic        i_wb_cp0_we,
  input  logic [4:0]  i_wb_cp0_waddr,
  input  logic [31:0] i_wb_cp0_wdata,
  output logic [31:0] o_excepttype,
  output logic [31:0] o_current_inst_addr,
  output logic        o_is_in_delayslot,
  output logic        o_flush,
  output logic [31:0] o_new_pc
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_req;
  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        flush_nxt;
  logic [31:0] new_pc_nxt;

  cp0_bypass u_bypass (
    .cp0_status (i_cp0_status),
    .cp0_cause  (i_cp0_cause),
    .cp0_epc    (i_cp0_epc),
    .wb_we      (i_wb_cp0_we),
    .wb_waddr   (i_wb_cp0_waddr),
    .wb_wdata   (i_wb_cp0_wdata),
    .status_eff (status_eff),
    .cause_eff  (cause_eff),
    .epc_eff    (epc_eff)
  );

  // Pending & enabled, interrupts globally enabled (IE), not already in exception level (EXL)
  assign int_req = (|(cause_eff[15:8] & status_eff[15:8])) && status_eff[0] && !status_eff[1];

  // Instructions in MEM during a flush are being squashed and must not reach CP0
  assign o_excepttype = (i_mem_valid && state == ST_IDLE) ? prio_code(int_req, i_mem_except[12:8])
                                                          : EXC_NONE;
  assign o_current_inst_addr = i_mem_pc;
  assign o_is_in_delayslot   = i_mem_in_delayslot;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    flush_nxt  = o_flush;
    new_pc_nxt = o_new_pc;
    case (state)
      ST_IDLE: begin
        if (o_excepttype != EXC_NONE) begin
          state_nxt  = ST_FLUSH;
          cnt_nxt    = CNT_INIT;
          flush_nxt  = 1'b1;
          new_pc_nxt = (o_excepttype == EXC_ERET) ? epc_eff : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_IDLE;
          flush_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        flush_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      o_flush  <= 1'b0;
      o_new_pc <= 32'h0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_flush  <= flush_nxt;
      o_new_pc <= new_pc_nxt;
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: three instances (FLUSH_CYCLES 1, 3, 4)
// share the same stimulus; each scenario checks the instance it targets.
// Inputs change 1 time unit after the rising edge; outputs are read after that.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_ds;
  logic [31:0] mem_except;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  logic [31:0] exc1, exc3, exc4;
  logic [31:0] addr1, addr3, addr4;
  logic        ds1, ds3, ds4;
  logic        flush1, flush3, flush4;
  logic [31:0] npc1, npc3, npc4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  except_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .i_mem_valid(mem_valid), .i_mem_pc(mem_pc),
    .i_mem_in_delayslot(mem_ds), .i_mem_except(mem_except),
    .i_cp0_status(cp0_status), .i_cp0_cause(cp0_cause), .i_cp0_epc(cp0_epc),
    .i_wb_cp0_we(wb_we), .i_wb_cp0_waddr(wb_waddr), .i_wb_cp0_wdata(wb_wdata),
    .o_excepttype(exc1), .o_current_inst_addr(addr1), .o_is_in_delayslot(ds1),
    .o_flush(flush1), .o_new_pc(npc1));

  except_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .i_mem_valid(mem_valid), .i_mem_pc(mem_pc),
    .i_mem_in_delayslot(mem_ds), .i_mem_except(mem_except),
    .i_cp0_status(cp0_status), .i_cp0_cause(cp0_cause), .i_cp0_epc(cp0_epc),
    .i_wb_cp0_we(wb_we), .i_wb_cp0_waddr(wb_waddr), .i_wb_cp0_wdata(wb_wdata),
    .o_excepttype(exc3), .o_current_inst_addr(addr3), .o_is_in_delayslot(ds3),
    .o_flush(flush3), .o_new_pc(npc3));

  except_ctrl #(.FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .i_mem_valid(mem_valid), .i_mem_pc(mem_pc),
    .i_mem_in_delayslot(mem_ds), .i_mem_except(mem_except),
    .i_cp0_status(cp0_status), .i_cp0_cause(cp0_cause), .i_cp0_epc(cp0_epc),
    .i_wb_cp0_we(wb_we), .i_wb_cp0_waddr(wb_waddr), .i_wb_cp0_wdata(wb_wdata),
    .o_excepttype(exc4), .o_current_inst_addr(addr4), .o_is_in_delayslot(ds4),
    .o_flush(flush4), .o_new_pc(npc4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Idle with no valid instruction long enough for every instance to leave FLUSH
  task automatic idle(input int n);
    mem_valid  = 1'b0;
    mem_except = 32'h0;
    wb_we      = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0; mem_pc = 32'h0; mem_ds = 1'b0; mem_except = 32'h0;
    cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
    #2;
    // Reset state
    chk("rst_flush", {31'h0, flush1}, 32'h0);
    chk("rst_new_pc", npc1, 32'h0);
    chk("rst_exc", exc1, 32'h0);
    mem_pc = 32'h1234; mem_ds = 1'b1; mem_except = 32'h100;
    settle();
    chk("rst_addr_follow", addr1, 32'h1234);
    chk("rst_ds_follow", {31'h0, ds1}, 32'h1);
    chk("rst_exc_invalid", exc1, 32'h0);
    tick();
    rst = 1'b0;
    mem_ds = 1'b0;
    idle(2);

    // Syscall, FLUSH_CYCLES=1
    mem_valid = 1'b1; mem_except = 32'h100; mem_pc = 32'h80;
    settle();
    chk("sys_exc", exc1, 32'h8);
    chk("sys_addr", addr1, 32'h80);
    chk("sys_ds", {31'h0, ds1}, 32'h0);
    tick();
    chk("sys_flush", {31'h0, flush1}, 32'h1);
    chk("sys_new_pc", npc1, 32'h20);
    chk("sys_exc_in_flush", exc1, 32'h0);
    mem_valid = 1'b0; mem_except = 32'h0;
    tick();
    chk("sys_flush_end", {31'h0, flush1}, 32'h0);
    idle(6);

    // ERET with EPC bypass
    mem_valid = 1'b1; mem_except = 32'h1000; cp0_epc = 32'h100;
    wb_we = 1'b1; wb_waddr = 5'd14; wb_wdata = 32'h200;
    settle();
    chk("eret_exc", exc1, 32'hE);
    tick();
    chk("eret_flush", {31'h0, flush1}, 32'h1);
    chk("eret_new_pc", npc1, 32'h200);
    idle(6);
    cp0_epc = 32'h0;

    // Priority among simultaneous flags, interrupts disabled
    mem_except = 32'hC00;
    settle();
    chk("prio_valid0", exc1, 32'h0);
    mem_valid = 1'b1;
    settle();
    chk("prio_trap_over_ov", exc1, 32'hD);
    mem_except = 32'h300;
    settle();
    chk("prio_sys_over_inv", exc1, 32'h8);
    mem_except = 32'h1800;
    settle();
    chk("prio_ov_over_eret", exc1, 32'hC);

    // Interrupt gating
    cp0_cause = 32'h400; cp0_status = 32'h401; mem_except = 32'h800;
    settle();
    chk("int_over_ov", exc1, 32'h1);
    cp0_status = 32'h403;
    settle();
    chk("int_exl_blocks", exc1, 32'hC);
    cp0_status = 32'h400;
    settle();
    chk("int_ie_clear", exc1, 32'hC);
    mem_valid = 1'b0;
    cp0_status = 32'h0; cp0_cause = 32'h0;
    idle(6);

    // Flush window with FLUSH_CYCLES=3
    mem_valid = 1'b1; mem_except = 32'h100;
    settle();
    chk("fw_exc", exc3, 32'h8);
    tick();
    mem_except = 32'h400;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fw_flush_%0d", i), {31'h0, flush3}, 32'h1);
      chk($sformatf("fw_exc_%0d", i), exc3, 32'h0);
      chk($sformatf("fw_pc_%0d", i), npc3, 32'h20);
      tick();
    end
    chk("fw_flush_done", {31'h0, flush3}, 32'h0);
    chk("fw_trap_after", exc3, 32'hD);
    idle(8);

    // Software interrupt through Cause bypass
    cp0_status = 32'h101; cp0_cause = 32'h0;
    mem_valid = 1'b1; mem_except = 32'h0;
    wb_we = 1'b1; wb_waddr = 5'd13; wb_wdata = 32'hFFFF_FC00;
    settle();
    chk("swint_other_bits_not_fwd", exc1, 32'h0);
    wb_wdata = 32'h0000_0100;
    settle();
    chk("swint_bypass", exc1, 32'h1);
    wb_waddr = 5'd12;
    settle();
    chk("swint_wrong_reg", exc1, 32'h0);
    idle(6);
    cp0_status = 32'h0;

    // Reset in the middle of a flush, FLUSH_CYCLES=4
    mem_valid = 1'b1; mem_except = 32'h200;
    settle();
    chk("rf_exc", exc4, 32'hA);
    tick();
    mem_valid = 1'b0; mem_except = 32'h0;
    chk("rf_flush1", {31'h0, flush4}, 32'h1);
    tick();
    chk("rf_flush2", {31'h0, flush4}, 32'h1);
    rst = 1'b1;
    settle();
    chk("rf_rst_flush", {31'h0, flush4}, 32'h0);
    chk("rf_rst_pc", npc4, 32'h0);
    tick();
    rst = 1'b0;
    mem_valid = 1'b1; mem_except = 32'h800;
    settle();
    chk("rf_after_exc", exc4, 32'hC);
    tick();
    chk("rf_after_flush", {31'h0, flush4}, 32'h1);
    chk("rf_after_pc", npc4, 32'h20);
    idle(6);
    chk("rf_final_idle", {31'h0, flush4}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
